uart_rx_majority: RTL and testbench

Byte receiver feeding the system-control command FSM: converts the asynchronous serial `rx_in` line from the host into one-cycle `rx_valid` strobes with `rx_data`, 8N1 framing, LSB first. It sits between the board UART RX pin and the command decoder. It adds input synchronisation, 3-sample majority voting per bit, false-start rejection, framing-error reporting and break detection, so line noise never produces spurious command bytes.

---
 rtl/uart_rx_majority.sv | 116 +++++++++++
 tb/tb_uart_rx_majority.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_majority.sv
// uart_rx_majority: 8N1 UART receiver with 3-sample majority vote, false-start rejection, framing error and break detection
module uart_rx_majority #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       frame_err,
  output logic       break_det,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  // cnt reaches CLKS_PER_BIT exactly on every bit centre, including the start bit
  localparam logic [CW-1:0] C_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_MID = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_P1 = CW'(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] START_LD = CW'(CLKS_PER_BIT - CLKS_PER_BIT / 2 + 1);
  localparam logic [CW-1:0] RELOAD = CW'(2);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t state, state_n;
  logic s1, s, s_d;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n, data_n;
  logic v0, v1, v0_n, v1_n;
  logic vote, decide, valid_n, ferr_n, brk_n;
  assign vote = (v0 & v1) | (v0 & s) | (v1 & s);
  assign decide = cnt == C_P1;
  assign busy = state != IDLE;
  // two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) {s1, s, s_d} <= 3'b111;
    else {s1, s, s_d} <= {rx_in, s1, s};
  end
  // next-state, sampling and output decisions
  always_comb begin
    state_n = state;
    cnt_n = cnt + CW'(1);
    idx_n = idx;
    sh_n = sh;
    data_n = rx_data;
    valid_n = 1'b0;
    ferr_n = 1'b0;
    brk_n = break_det;
    v0_n = (cnt == C_M1) ? s : v0;
    v1_n = (cnt == C_MID) ? s : v1;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (s_d && !s) begin
          state_n = START;
          cnt_n = START_LD;
        end
      end
      START: if (decide) begin
        state_n = vote ? IDLE : DATA;
        cnt_n = RELOAD;
        idx_n = '0;
      end
      DATA: if (decide) begin
        sh_n[idx] = vote;
        cnt_n = RELOAD;
        idx_n = idx + 3'd1;
        if (idx == 3'd7) state_n = STOP;
      end
      STOP: if (decide) begin
        cnt_n = '0;
        if (vote) begin
          data_n = sh;
          valid_n = 1'b1;
          state_n = IDLE;
        end else begin
          ferr_n = 1'b1;
          brk_n = sh == 8'h00;
          state_n = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        cnt_n = '0;
        if (s) begin
          brk_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  // state, datapath and registered output strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      v0 <= 1'b1;
      v1 <= 1'b1;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      break_det <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      v0 <= v0_n;
      v1 <= v1_n;
      rx_data <= data_n;
      rx_valid <= valid_n;
      frame_err <= ferr_n;
      break_det <= brk_n;
    end
  end
endmodule

// File: tb/tb_uart_rx_majority.sv
// tb_uart_rx_majority: vector table, corner-case sequences and randomized baud-skewed frames against a frame-level model
module tb_uart_rx_majority;
  localparam int C = 16;
  logic clk = 0, rst = 1, rx_in = 1;
  logic rx_valid, frame_err, break_det, busy;
  logic [7:0] rx_data;
  uart_rx_majority #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .rx_valid(rx_valid), .rx_data(rx_data),
    .frame_err(frame_err), .break_det(break_det), .busy(busy)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int nchk = 0, nerr = 0;
  int nvalid = 0, nferr = 0, nbrk = 0, unstable = 0;
  int last_valid_cyc = -1, last_ferr_cyc = -1, busy_rise = -1, busy_fall = -1, brk_fall = -1;
  logic [7:0] q_data[$];
  logic [7:0] prev_data = 8'h00;
  logic prev_busy = 1'b0, prev_brk = 1'b0;
  // passive monitor on the falling edge, away from the DUT's active edge
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        nvalid++;
        q_data.push_back(rx_data);
        last_valid_cyc = cyc;
      end
      if (frame_err) begin
        nferr++;
        last_ferr_cyc = cyc;
      end
      if (break_det && !prev_brk) nbrk++;
      if (!break_det && prev_brk) brk_fall = cyc;
      if (busy && !prev_busy) busy_rise = cyc;
      if (!busy && prev_busy) busy_fall = cyc;
      if (rst && !rx_valid && rx_data !== prev_data) unstable++;
      prev_data = rx_data;
      prev_busy = busy;
      prev_brk = break_det;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  // drive a level for n whole clock cycles; entered and left at posedge+1
  task automatic hold(input logic v, input int n);
    rx_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic stop, output int p);
    p = cyc;
    hold(1'b0, C);
    for (int i = 0; i < 8; i++) hold(d[i], C);
    hold(stop, C);
  endtask
  task automatic send_async(input logic [7:0] d, input logic stop, input int per);
    rx_in = 1'b0;
    #(per);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      #(per);
    end
    rx_in = stop;
    #(per);
    rx_in = 1'b1;
  endtask
  typedef struct {
    logic [7:0] d;
    logic stop;
    int gap;
    logic valid;
    logic ferr;
    logic [7:0] data;
  } vec_t;
  vec_t vecs[7];
  initial begin
    int p, r, nv, nf, nb, per, gap, exp_ferr, exp_brk;
    logic [7:0] d, last_good;
    logic stop;
    logic [7:0] exp_q[$];
    vecs[0] = '{8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{8'hFF, 1'b1, 0, 1'b1, 1'b0, 8'hFF};
    vecs[2] = '{8'h05, 1'b1, 4, 1'b1, 1'b0, 8'h05};
    vecs[3] = '{8'h55, 1'b0, 8, 1'b0, 1'b1, 8'h05};
    vecs[4] = '{8'h3C, 1'b1, 4, 1'b1, 1'b0, 8'h3C};
    vecs[5] = '{8'hC3, 1'b0, 8, 1'b0, 1'b1, 8'h3C};
    vecs[6] = '{8'h69, 1'b1, 4, 1'b1, 1'b0, 8'h69};
    #1 rst = 0;
    #20;
    chk("reset outputs", {rx_valid, rx_data, frame_err, break_det, busy}, 12'h000);
    @(posedge clk);
    #1 rst = 1;
    hold(1'b1, 4);
    // single byte with exact latency
    nv = nvalid;
    nf = nferr;
    send(8'hA5, 1'b1, p);
    hold(1'b1, 4);
    chk("a5 count", nvalid - nv, 1);
    chk("a5 cycle", last_valid_cyc, p + 2 + 8 + 144 + 2);
    chk("a5 data", rx_data, 8'hA5);
    chk("a5 ferr", nferr - nf, 0);
    chk("a5 busy rise", busy_rise, p + 3);
    chk("a5 busy fall", busy_fall >= p + 156 && busy_fall <= p + 157, 1);
    // table: back-to-back frames, framing errors and recovery
    for (int i = 0; i < 7; i++) begin
      nv = nvalid;
      nf = nferr;
      send(vecs[i].d, vecs[i].stop, p);
      if (vecs[i].gap > 0) hold(1'b1, vecs[i].gap);
      chk($sformatf("vec%0d valid", i), nvalid - nv, vecs[i].valid);
      chk($sformatf("vec%0d ferr", i), nferr - nf, vecs[i].ferr);
      chk($sformatf("vec%0d data", i), rx_data, vecs[i].data);
    end
    chk("table order", q_data.size() >= 5 && q_data[1] == 8'h00 && q_data[2] == 8'hFF && q_data[3] == 8'h05, 1);
    // 3-clock low pulse is a false start
    nv = nvalid;
    nf = nferr;
    p = cyc;
    hold(1'b0, 3);
    hold(1'b1, 30);
    chk("noise out", (nvalid - nv) + (nferr - nf), 0);
    chk("noise busy fall", busy_fall, p + 2 + 10);
    // one-clock inverted glitch at the centre of data bit 3
    nv = nvalid;
    d = 8'h5A;
    p = cyc;
    hold(1'b0, C);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        hold(d[i], 8);
        hold(~d[i], 1);
        hold(d[i], 7);
      end else hold(d[i], C);
    end
    hold(1'b1, C);
    hold(1'b1, 4);
    chk("glitch count", nvalid - nv, 1);
    chk("glitch data", rx_data, 8'h5A);
    // break: 20 bit times low
    nv = nvalid;
    nf = nferr;
    nb = nbrk;
    p = cyc;
    hold(1'b0, 20 * C);
    chk("break level", break_det, 1'b1);
    chk("break ferr", nferr - nf, 1);
    chk("break ferr cycle", last_ferr_cyc, p + 156);
    chk("break no valid", nvalid - nv, 0);
    chk("break data kept", rx_data, 8'h5A);
    r = cyc;
    hold(1'b1, 10);
    chk("break rises", nbrk - nb, 1);
    chk("break fall", (brk_fall - r) >= 2 && (brk_fall - r) <= 3, 1);
    chk("break cleared", break_det, 1'b0);
    nv = nvalid;
    send(8'h04, 1'b1, p);
    hold(1'b1, 4);
    chk("after break count", nvalid - nv, 1);
    chk("after break data", rx_data, 8'h04);
    // reset in the middle of data bit 4
    d = 8'h81;
    hold(1'b0, C);
    for (int i = 0; i < 4; i++) hold(d[i], C);
    hold(d[4], 8);
    rst = 0;
    #2;
    chk("mid reset outputs", {rx_valid, rx_data, frame_err, break_det, busy}, 12'h000);
    rx_in = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1;
    nv = nvalid;
    nf = nferr;
    hold(1'b1, 200);
    chk("post reset quiet", (nvalid - nv) + (nferr - nf), 0);
    chk("post reset idle", busy, 1'b0);
    send(8'h81, 1'b1, p);
    hold(1'b1, 4);
    chk("post reset count", nvalid - nv, 1);
    chk("post reset data", rx_data, 8'h81);
    // randomized frames with up to +/-2.5% baud skew, random phase and gaps
    q_data.delete();
    nf = nferr;
    nb = nbrk;
    exp_ferr = 0;
    exp_brk = 0;
    last_good = 8'h81;
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom);
      stop = $urandom_range(0, 4) != 0;
      if (i % 8 == 7) begin
        d = 8'h00;
        stop = 1'b0;
      end
      per = $urandom_range(156, 164);
      #($urandom_range(1, 9));
      send_async(d, stop, per);
      gap = stop ? $urandom_range(per / 2, 3 * per) : $urandom_range(per, 3 * per);
      #(gap);
      if (stop) begin
        exp_q.push_back(d);
        last_good = d;
      end else begin
        exp_ferr++;
        if (d == 8'h00) exp_brk++;
      end
    end
    @(posedge clk);
    #1;
    hold(1'b1, 40);
    chk("rand count", q_data.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < q_data.size(); i++)
      chk($sformatf("rand byte%0d", i), q_data[i], exp_q[i]);
    chk("rand ferr", nferr - nf, exp_ferr);
    chk("rand breaks", nbrk - nb, exp_brk);
    chk("rand last data", rx_data, last_good);
    chk("data stable between pulses", unstable, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
